// File: rtl/vc_pkg.sv
// Shared definitions for the VC traffic generator: state/mode encodings,
// LFSR constants and the field-width helpers for the emitted word.
package vc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tg_state_e;

    typedef enum logic [1:0] {
        MODE_RR    = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_RSVD  = 2'd3
    } tg_mode_e;

    // x^8 + x^6 + x^5 + x^4 + 1: taps on bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int unsigned class_bits(input int unsigned num_vc);
        return $clog2(num_vc);
    endfunction

    function automatic int unsigned dest_bits(input int unsigned num_dest);
        return $clog2(num_dest);
    endfunction

    function automatic int unsigned payload_bits(input int unsigned data_width,
                                                 input int unsigned num_vc,
                                                 input int unsigned num_dest);
        return data_width - $clog2(num_vc) - $clog2(num_dest);
    endfunction

endpackage

// File: rtl/vc_traffic_gen_if.sv
// Push/pop bus between the traffic generator and the VC / destination FIFOs.
interface vc_traffic_gen_if #(
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned NUM_DEST   = 2,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [NUM_VC-1:0]     push_vc;
    logic [DATA_WIDTH-1:0] data_out;
    logic [NUM_DEST-1:0]   pop_d;
    logic [NUM_VC-1:0]     vc_almost_full;
    logic [NUM_DEST-1:0]   dest_empty;

    modport master (
        output push_vc, data_out, pop_d,
        input  vc_almost_full, dest_empty
    );

    modport slave (
        input  push_vc, data_out, pop_d,
        output vc_almost_full, dest_empty
    );
endinterface

// File: rtl/tg_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load of the package seed and advance enable.
module tg_lfsr8
    import vc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_L,
    input  logic       load,
    input  logic       adv,
    output logic [7:0] q
);
    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            q <= LFSR_SEED;
        end else if (load) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= {q[6:0], fb};
        end
    end
endmodule

// File: rtl/vc_traffic_gen.sv
// Traffic generator: emits class/destination-tagged words into the VC FIFOs
// under almost-full backpressure, then pops the destination FIFOs until drained.
module vc_traffic_gen
    import vc_pkg::*;
#(
    parameter int unsigned NUM_VC        = 2,
    parameter int unsigned NUM_DEST      = 2,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TH_WIDTH      = 10,
    parameter int unsigned AF_VC         = 6,
    parameter int unsigned AE_VC         = 4,
    parameter int unsigned AF_D          = 5,
    parameter int unsigned AE_D          = 3,
    parameter int unsigned PAYLOAD_SEED  = 3,
    parameter int unsigned DRAIN_IDLE    = 8,
    parameter int unsigned DRAIN_TIMEOUT = 256
) (
    input  logic                             clk,
    input  logic                             reset_L,
    input  logic                             start,
    input  logic [15:0]                      pkt_count,
    input  logic [1:0]                       mode,
    input  logic [class_bits(NUM_VC)-1:0]    fixed_class,
    input  logic [dest_bits(NUM_DEST)-1:0]   fixed_dest,
    vc_traffic_gen_if.master                 bus,
    output logic [TH_WIDTH-1:0]              afVC_o,
    output logic [TH_WIDTH-1:0]              aeVC_o,
    output logic [TH_WIDTH-1:0]              afD_o,
    output logic [TH_WIDTH-1:0]              aeD_o,
    output logic [15:0]                      pop_total,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err
);
    localparam int unsigned CB = class_bits(NUM_VC);
    localparam int unsigned DB = dest_bits(NUM_DEST);
    localparam int unsigned PB = payload_bits(DATA_WIDTH, NUM_VC, NUM_DEST);
    localparam int unsigned IW = $clog2(DRAIN_IDLE + 1);
    localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

    tg_state_e             state_q, state_nxt;
    tg_mode_e              mode_q, mode_nxt;
    logic [15:0]           cnt_q, cnt_nxt;
    logic [15:0]           sent_q, sent_nxt;
    logic [PB-1:0]         payload_q, payload_nxt;
    logic [IW-1:0]         idle_q, idle_nxt;
    logic [TW-1:0]         drain_q, drain_nxt;
    logic [15:0]           pop_total_nxt;
    logic                  timeout_nxt, busy_nxt, done_nxt;
    logic [NUM_VC-1:0]     push_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [NUM_DEST-1:0]   pop_nxt;
    logic                  lfsr_load, lfsr_adv;
    logic [7:0]            lfsr_q;
    logic [CB-1:0]         tgt_class;
    logic [DB-1:0]         tgt_dest;

    assign afVC_o = TH_WIDTH'(AF_VC);
    assign aeVC_o = TH_WIDTH'(AE_VC);
    assign afD_o  = TH_WIDTH'(AF_D);
    assign aeD_o  = TH_WIDTH'(AE_D);

    tg_lfsr8 u_lfsr (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (lfsr_load),
        .adv     (lfsr_adv),
        .q       (lfsr_q)
    );

    // Target class/destination for the word at the head of the stream
    always_comb begin
        tgt_class = CB'(sent_q);
        tgt_dest  = DB'(sent_q >> CB);
        case (mode_q)
            MODE_FIXED: begin
                tgt_class = fixed_class;
                tgt_dest  = fixed_dest;
            end
            MODE_LFSR: begin
                tgt_class = CB'(lfsr_q);
                tgt_dest  = DB'(lfsr_q >> CB);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RR;
            cnt_q        <= '0;
            sent_q       <= '0;
            payload_q    <= '0;
            idle_q       <= '0;
            drain_q      <= '0;
            pop_total    <= '0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.push_vc  <= '0;
            bus.data_out <= '0;
            bus.pop_d    <= '0;
        end else begin
            state_q      <= state_nxt;
            mode_q       <= mode_nxt;
            cnt_q        <= cnt_nxt;
            sent_q       <= sent_nxt;
            payload_q    <= payload_nxt;
            idle_q       <= idle_nxt;
            drain_q      <= drain_nxt;
            pop_total    <= pop_total_nxt;
            timeout_err  <= timeout_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            bus.push_vc  <= push_nxt;
            bus.data_out <= data_nxt;
            bus.pop_d    <= pop_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        mode_nxt      = mode_q;
        cnt_nxt       = cnt_q;
        sent_nxt      = sent_q;
        payload_nxt   = payload_q;
        idle_nxt      = idle_q;
        drain_nxt     = drain_q;
        pop_total_nxt = pop_total + 16'($countones(bus.pop_d));
        timeout_nxt   = timeout_err;
        push_nxt      = '0;
        data_nxt      = bus.data_out;
        lfsr_load     = 1'b0;
        lfsr_adv      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    timeout_nxt   = 1'b0;
                    pop_total_nxt = '0;
                    if (pkt_count == 16'd0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt   = ST_SEND;
                        cnt_nxt     = pkt_count;
                        mode_nxt    = tg_mode_e'(mode);
                        sent_nxt    = '0;
                        payload_nxt = PB'(PAYLOAD_SEED);
                        idle_nxt    = '0;
                        drain_nxt   = '0;
                        lfsr_load   = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (!bus.vc_almost_full[tgt_class]) begin
                    push_nxt    = NUM_VC'(1) << tgt_class;
                    data_nxt    = {tgt_dest, tgt_class, payload_q};
                    sent_nxt    = sent_q + 16'd1;
                    payload_nxt = payload_q + PB'(1);
                    lfsr_adv    = 1'b1;
                    if (sent_q == cnt_q - 16'd1) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_nxt = drain_q + TW'(1);
                if (&bus.dest_empty) begin
                    idle_nxt = idle_q + IW'(1);
                    if (idle_q == IW'(DRAIN_IDLE - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    idle_nxt = '0;
                end
                // A clean drain on the last allowed cycle wins over the timeout
                if (state_nxt != ST_DONE && drain_q == TW'(DRAIN_TIMEOUT - 1)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            default: ;
        endcase

        pop_nxt  = ((state_q == ST_SEND || state_q == ST_DRAIN) && state_nxt != ST_DONE)
                   ? ~bus.dest_empty : '0;
        busy_nxt = (state_nxt == ST_SEND) || (state_nxt == ST_DRAIN);
        done_nxt = (state_nxt == ST_DONE);
    end
endmodule

// File: tb/tb_vc_traffic_gen.sv
// Self-checking bench for vc_traffic_gen: directed runs with random backpressure,
// a word-stream reference model and a simple destination-FIFO occupancy model.
module tb_vc_traffic_gen;
    localparam int unsigned NV = 2;
    localparam int unsigned ND = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 10;
    localparam int unsigned CB = 1;
    localparam int unsigned DB = 1;
    localparam int unsigned PB = DW - CB - DB;
    localparam int unsigned DRAIN_IDLE    = 8;
    localparam int unsigned DRAIN_TIMEOUT = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_L;
    logic          start;
    logic [15:0]   pkt_count;
    logic [1:0]    mode;
    logic [CB-1:0] fixed_class;
    logic [DB-1:0] fixed_dest;
    logic [TW-1:0] afVC_o, aeVC_o, afD_o, aeD_o;
    logic [15:0]   pop_total;
    logic          busy, done, timeout_err;

    vc_traffic_gen_if #(.NUM_VC(NV), .NUM_DEST(ND), .DATA_WIDTH(DW)) bus ();

    vc_traffic_gen #(
        .NUM_VC(NV), .NUM_DEST(ND), .DATA_WIDTH(DW), .TH_WIDTH(TW),
        .AF_VC(6), .AE_VC(4), .AF_D(5), .AE_D(3), .PAYLOAD_SEED(3),
        .DRAIN_IDLE(DRAIN_IDLE), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .start       (start),
        .pkt_count   (pkt_count),
        .mode        (mode),
        .fixed_class (fixed_class),
        .fixed_dest  (fixed_dest),
        .bus         (bus),
        .afVC_o      (afVC_o),
        .aeVC_o      (aeVC_o),
        .afD_o       (afD_o),
        .aeD_o       (aeD_o),
        .pop_total   (pop_total),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    int            m_fifo [ND];
    logic [NV-1:0] vis_push;
    logic [DW-1:0] vis_data;
    logic [ND-1:0] vis_pop;
    logic [DW-1:0] m_last;
    logic [DW-1:0] words [$];
    logic [NV-1:0] pushes [$];
    logic [7:0]    rr_tbl [8] = '{8'h03, 8'h44, 8'h85, 8'hC6, 8'h07, 8'h48, 8'h89, 8'hCA};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Polynomial x^8 + x^6 + x^5 + x^4 + 1; the x^k term feeds from bit k-1
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int   taps [4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (taps[i]) fb = fb ^ s[taps[i] - 1];
        return {s[6:0], fb};
    endfunction

    // Empty flag of each destination FIFO, accounting for a pop already in flight
    task automatic drive_empty(input bit hold0);
        logic [ND-1:0] de;
        for (int i = 0; i < ND; i++) de[i] = (m_fifo[i] - int'(vis_pop[i])) <= 0;
        if (hold0) de[0] = 1'b0;
        bus.dest_empty = de;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
        if (vis_push != '0) m_fifo[int'(vis_data >> (CB + PB))]++;
        for (int i = 0; i < ND; i++) if (vis_pop[i] && m_fifo[i] > 0) m_fifo[i]--;
        vis_push = bus.push_vc;
        vis_data = bus.data_out;
        vis_pop  = bus.pop_d;
    endtask

    task automatic run(input int cnt, input logic [1:0] md, input int bp,
                       input bit hold0, input bit poke_start, input string tag);
        int            sent, payload, n_push, rise_c, last_c, done_c, cls, dst;
        logic [7:0]    lf;
        logic [NV-1:0] af, exp_push;
        logic [DW-1:0] exp_data;
        bit            sending, ae, ae_prev;

        words.delete();
        pushes.delete();
        pkt_count = 16'(cnt);
        mode      = md;
        start     = 1'b1;
        clock_edge();
        start = 1'b0;
        chk({tag, "/launch_push"}, 32'(bus.push_vc), 32'd0);
        chk({tag, "/launch_busy"}, 32'(busy), 32'(cnt != 0));
        chk({tag, "/launch_done"}, 32'(done), 32'(cnt == 0));
        if (cnt == 0) begin
            chk({tag, "/pop_total"}, 32'(pop_total), 32'd0);
            chk({tag, "/timeout_err"}, 32'(timeout_err), 32'd0);
            return;
        end

        sent = 0; payload = 3; lf = 8'hA5; sending = 1'b1; ae_prev = 1'b1;
        n_push = 0; rise_c = -1; last_c = -1; done_c = -1;
        for (int c = 1; c <= 2000 && done_c < 0; c++) begin
            case (md)
                2'd1:    begin cls = int'(fixed_class); dst = int'(fixed_dest); end
                2'd2:    begin cls = int'(lf) % NV; dst = (int'(lf) / NV) % ND; end
                default: begin cls = sent % NV; dst = (sent / NV) % ND; end
            endcase
            af = '0;
            if (bp == 1 && c >= 2 && c <= 4) af[1] = 1'b1;
            else if (bp == 2) af = NV'($urandom) & NV'($urandom);
            bus.vc_almost_full = af;
            drive_empty(hold0);
            if (poke_start && c == 3) begin
                start = 1'b1; pkt_count = 16'd99; mode = 2'd2;
            end
            ae = &bus.dest_empty;
            if (ae && !ae_prev) rise_c = c;
            ae_prev = ae;

            exp_push = '0;
            exp_data = m_last;
            if (sending && !af[cls]) begin
                exp_push = NV'(1) << cls;
                exp_data = DW'(dst * (2 ** (CB + PB)) + cls * (2 ** PB) + payload % (2 ** PB));
                sent++;
                payload++;
                lf = lfsr_next(lf);
                if (sent == cnt) begin
                    sending = 1'b0;
                    last_c  = c + 1;
                end
            end
            clock_edge();
            start  = 1'b0;
            m_last = exp_data;
            chk({tag, "/push_vc"}, 32'(bus.push_vc), 32'(exp_push));
            chk({tag, "/data_out"}, 32'(bus.data_out), 32'(exp_data));
            if (bus.push_vc != '0) begin
                n_push++;
                words.push_back(bus.data_out);
                pushes.push_back(bus.push_vc);
            end
            if (done) done_c = c + 1;
        end

        chk({tag, "/done_seen"}, 32'(done_c > 0), 32'd1);
        chk({tag, "/push_count"}, n_push, cnt);
        if (hold0) begin
            chk({tag, "/timeout_err"}, 32'(timeout_err), 32'd1);
            chk({tag, "/timeout_cycles"}, done_c - last_c, DRAIN_TIMEOUT);
        end else begin
            chk({tag, "/timeout_err"}, 32'(timeout_err), 32'd0);
            chk({tag, "/idle_to_done"}, done_c - rise_c, DRAIN_IDLE);
            chk({tag, "/pop_total"}, 32'(pop_total), cnt);
        end
        chk({tag, "/busy_end"}, 32'(busy), 32'd0);
        chk({tag, "/pop_d_done"}, 32'(bus.pop_d), 32'd0);
        bus.vc_almost_full = '0;
        drive_empty(1'b0);
    endtask

    initial begin
        reset_L = 1'b0; start = 1'b0; pkt_count = '0; mode = '0;
        fixed_class = '0; fixed_dest = '0;
        bus.vc_almost_full = '0;
        bus.dest_empty = '1;
        for (int i = 0; i < ND; i++) m_fifo[i] = 0;
        vis_push = '0; vis_data = '0; vis_pop = '0; m_last = '0;

        repeat (2) clock_edge();
        chk("reset/push_vc", 32'(bus.push_vc), 32'd0);
        chk("reset/data_out", 32'(bus.data_out), 32'd0);
        chk("reset/pop_d", 32'(bus.pop_d), 32'd0);
        chk("reset/pop_total", 32'(pop_total), 32'd0);
        chk("reset/busy_done_to", 32'({busy, done, timeout_err}), 32'd0);
        chk("reset/afVC", 32'(afVC_o), 32'd6);
        chk("reset/aeVC", 32'(aeVC_o), 32'd4);
        chk("reset/afD", 32'(afD_o), 32'd5);
        chk("reset/aeD", 32'(aeD_o), 32'd3);
        reset_L = 1'b1;
        clock_edge();
        drive_empty(1'b0);

        run(8, 2'd0, 0, 1'b0, 1'b0, "rr8");
        for (int i = 0; i < 8 && i < words.size(); i++) begin
            chk("rr8/word_tbl", 32'(words[i]), 32'(rr_tbl[i]));
            chk("rr8/push_alt", 32'(pushes[i]), (i % 2 == 1) ? 32'd2 : 32'd1);
        end

        fixed_class = 1'b1;
        fixed_dest  = 1'b0;
        run(4, 2'd1, 1, 1'b0, 1'b1, "fix4");
        for (int i = 0; i < 4 && i < words.size(); i++) begin
            chk("fix4/push_vc1", 32'(pushes[i]), 32'd2);
            chk("fix4/payload", 32'(words[i]), 32'h40 + 32'(3 + i));
        end

        run(16, 2'd2, 2, 1'b0, 1'b0, "lfsr16");
        run(70, 2'd3, 2, 1'b0, 1'b0, "rsvd70_wrap");
        run(4, 2'd0, 0, 1'b1, 1'b0, "timeout");
        chk("timeout/sticky", 32'(timeout_err), 32'd1);
        chk("timeout/done_hold", 32'(done), 32'd1);
        run(0, 2'd0, 0, 1'b0, 1'b0, "zero");

        // Reset in the middle of a run, then relaunch from scratch
        pkt_count = 16'd10; mode = 2'd0; start = 1'b1;
        clock_edge();
        start = 1'b0;
        repeat (3) clock_edge();
        chk("midrst/pre_busy", 32'(busy), 32'd1);
        reset_L = 1'b0;
        clock_edge();
        chk("midrst/push_vc", 32'(bus.push_vc), 32'd0);
        chk("midrst/data_out", 32'(bus.data_out), 32'd0);
        chk("midrst/pop_d", 32'(bus.pop_d), 32'd0);
        chk("midrst/pop_total", 32'(pop_total), 32'd0);
        chk("midrst/busy_done_to", 32'({busy, done, timeout_err}), 32'd0);
        chk("midrst/afVC", 32'(afVC_o), 32'd6);
        reset_L = 1'b1;
        for (int i = 0; i < ND; i++) m_fifo[i] = 0;
        vis_push = '0; vis_data = '0; vis_pop = '0; m_last = '0;
        drive_empty(1'b0);
        run(3, 2'd0, 0, 1'b0, 1'b0, "rerun");
        chk("rerun/first_word", (words.size() > 0) ? 32'(words[0]) : 32'hFFFF, 32'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
